// File: rtl/serial_link_rx.sv
// Multi-lane serial receiver: assembles LANES-bit beats into WORD_WIDTH-bit words
// and buffers them in a DEPTH-entry FIFO with gap-timeout recovery and drop counting.
module serial_link_rx #(
    parameter int LANES      = 2,
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LANES-1:0]          serial_data,
    input  logic                      serial_ready,
    output logic [WORD_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      framing_error,
    output logic                      overflow,
    output logic [7:0]                drop_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int BEATS = WORD_WIDTH / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int GW    = $clog2(TIMEOUT + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT - 1);

    logic [WORD_WIDTH-1:0] r_shift;
    logic [WORD_WIDTH-1:0] w_shift_next;
    logic [CW-1:0]         r_beat_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_ferr;
    logic                  r_ovf;
    logic [7:0]            r_drop;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;

    logic                  w_busy;
    logic                  w_push;
    logic                  w_timeout;
    logic [LW-1:0]         w_level;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;

    // The shift direction decides which end the first beat lands in once the word is full.
    generate
        if (BEATS == 1) begin : g_single
            assign w_shift_next = serial_data;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign w_shift_next = {r_shift[WORD_WIDTH-LANES-1:0], serial_data};
        end else begin : g_lsb
            assign w_shift_next = {serial_data, r_shift[WORD_WIDTH-1:LANES]};
        end
    endgenerate

    assign w_busy    = (r_beat_cnt != '0);
    assign w_push    = serial_ready && (r_beat_cnt == LAST_BEAT);
    assign w_timeout = !serial_ready && w_busy && (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_ferr     <= 1'b0;
        end else begin
            r_ferr <= w_timeout;
            if (serial_ready) begin
                r_shift    <= w_shift_next;
                r_gap_cnt  <= '0;
                r_beat_cnt <= w_push ? '0 : r_beat_cnt + CW'(1);
            end else if (w_timeout) begin
                r_beat_cnt <= '0;
                r_gap_cnt  <= '0;
            end else if (w_busy) begin
                r_gap_cnt  <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt  <= '0;
            end
        end
    end

    // A pop frees the head slot in the same cycle, so a push onto a full FIFO still fits.
    assign w_level = r_wptr - r_rptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LW'(DEPTH));
    assign w_pop   = !w_empty && out_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= w_shift_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else begin
            r_ovf <= w_drop;
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign out_data      = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign out_valid     = !w_empty;
    assign busy          = w_busy;
    assign framing_error = r_ferr;
    assign overflow      = r_ovf;
    assign drop_count    = r_drop;
    assign fifo_level    = w_level;

endmodule

// File: tb/tb_serial_link_rx.sv
// Bench for serial_link_rx: LSB-first and MSB-first instances on shared stimulus,
// compared every cycle against a queue-based word/FIFO model.
module tb_serial_link_rx;

    localparam int LANES      = 2;
    localparam int WORD_WIDTH = 8;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 4;
    localparam int BEATS      = WORD_WIDTH / LANES;

    logic                  clock;
    logic                  reset;
    logic [LANES-1:0]      serial_data;
    logic                  serial_ready;
    logic                  out_ready;

    logic [WORD_WIDTH-1:0] out_data,      m_out_data;
    logic                  out_valid,     m_out_valid;
    logic                  busy,          m_busy;
    logic                  framing_error, m_framing_error;
    logic                  overflow,      m_overflow;
    logic [7:0]            drop_count,    m_drop_count;
    logic [2:0]            fifo_level,    m_fifo_level;

    serial_link_rx #(
        .LANES(LANES), .WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MSB_FIRST(0)
    ) dut (
        .clock(clock), .reset(reset), .serial_data(serial_data), .serial_ready(serial_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .framing_error(framing_error), .overflow(overflow), .drop_count(drop_count),
        .fifo_level(fifo_level)
    );

    serial_link_rx #(
        .LANES(LANES), .WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MSB_FIRST(1)
    ) dut_m (
        .clock(clock), .reset(reset), .serial_data(serial_data), .serial_ready(serial_ready),
        .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(out_ready), .busy(m_busy),
        .framing_error(m_framing_error), .overflow(m_overflow), .drop_count(m_drop_count),
        .fifo_level(m_fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending beats, idle count, FIFO contents for both beat orders.
    int         mbeats[$];
    int         mgap;
    logic [7:0] mfifo[$];
    logic [7:0] mfifo_m[$];
    int         mdrop;
    bit         mferr;
    bit         movf;

    task automatic model_clear();
        mbeats.delete();
        mfifo.delete();
        mfifo_m.delete();
        mgap  = 0;
        mdrop = 0;
        mferr = 0;
        movf  = 0;
    endtask

    task automatic model_step(input bit rdy, input logic [1:0] d, input bit ordy);
        bit         push;
        bit         pop;
        logic [7:0] wl;
        logic [7:0] wm;
        push  = 0;
        wl    = '0;
        wm    = '0;
        mferr = 0;
        movf  = 0;
        pop   = (mfifo.size() > 0) && ordy;
        if (rdy) begin
            mbeats.push_back(int'(d));
            mgap = 0;
            if (mbeats.size() == BEATS) begin
                for (int i = 0; i < BEATS; i++) begin
                    wl = wl | 8'(mbeats[i] << (LANES * i));
                    wm = wm | 8'(mbeats[i] << (WORD_WIDTH - LANES * (i + 1)));
                end
                push = 1;
                mbeats.delete();
            end
        end else if (mbeats.size() > 0) begin
            mgap++;
            if (mgap == TIMEOUT) begin
                mbeats.delete();
                mgap  = 0;
                mferr = 1;
            end
        end
        if (push && mfifo.size() == DEPTH && !pop) begin
            movf = 1;
            if (mdrop < 255) mdrop++;
            push = 0;
        end
        if (pop) begin
            void'(mfifo.pop_front());
            void'(mfifo_m.pop_front());
        end
        if (push) begin
            mfifo.push_back(wl);
            mfifo_m.push_back(wm);
        end
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, mfifo.size() > 0);
        chk("m_out_valid", m_out_valid, mfifo_m.size() > 0);
        if (mfifo.size() > 0) begin
            chk("out_data_lsb", out_data, mfifo[0]);
            chk("out_data_msb", m_out_data, mfifo_m[0]);
        end
        chk("busy", busy, mbeats.size() > 0);
        chk("framing_error", framing_error, mferr);
        chk("overflow", overflow, movf);
        chk("drop_count", drop_count, mdrop);
        chk("fifo_level", fifo_level, mfifo.size());
        chk("m_fifo_level", m_fifo_level, mfifo_m.size());
    endtask

    task automatic step(input bit rdy, input logic [1:0] d, input bit ordy);
        serial_ready = rdy;
        serial_data  = d;
        out_ready    = ordy;
        @(posedge clock);
        model_step(rdy, d, ordy);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [7:0] w, input bit ordy, input bit last_ordy);
        for (int i = 0; i < BEATS; i++) begin
            step(1'b1, 2'(w >> (LANES * i)), (i == BEATS - 1) ? last_ordy : ordy);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, ordy);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_m_out_data"}, m_out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_framing_error"}, framing_error, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
    endtask

    // Asserts reset between clock edges and checks the outputs before any edge arrives.
    task automatic apply_reset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_clear();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int thr;
        reset        = 1'b0;
        serial_ready = 1'b0;
        serial_data  = '0;
        out_ready    = 1'b0;
        model_clear();
        #2;
        check_reset_outputs("por");
        @(posedge clock);
        #3;
        reset = 1'b1;

        // Basic word in both beat orders
        send_word(8'hA5, 1'b1, 1'b1);
        chk("t1_data", out_data, 8'hA5);
        chk("t2_msb_data", m_out_data, 8'h5A);
        chk("t1_valid", out_valid, 1);
        idle(1, 1'b1);
        chk("t1_valid_one_cycle", out_valid, 0);
        chk("t1_level", fifo_level, 0);

        // Gap tolerance: 3 idles mid-word are absorbed
        step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b11, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 2'b01, 1'b1);
        step(1'b1, 2'b10, 1'b1);
        chk("t3_gap_word", out_data, 8'h9C);
        chk("t3_gap_no_ferr", framing_error, 0);
        idle(2, 1'b1);

        // Timeout: 4 idles mid-word discard the partial word
        step(1'b1, 2'b01, 1'b1);
        step(1'b1, 2'b01, 1'b1);
        idle(4, 1'b1);
        chk("t3_timeout_ferr", framing_error, 1);
        chk("t3_timeout_busy", busy, 0);
        idle(1, 1'b1);
        chk("t3_ferr_pulse", framing_error, 0);
        send_word(8'h3C, 1'b1, 1'b1);
        chk("t3_after_timeout", out_data, 8'h3C);
        idle(2, 1'b1);

        // Overflow
        for (int w = 1; w <= 6; w++) send_word(8'(w), 1'b0, 1'b0);
        chk("t4_level", fifo_level, 4);
        chk("t4_drops", drop_count, 2);
        for (int k = 1; k <= 4; k++) begin
            chk("t4_pop_order", out_data, k);
            step(1'b0, 2'b00, 1'b1);
        end
        chk("t4_drained", fifo_level, 0);

        // Push and pop together on a full FIFO
        for (int w = 8'h11; w <= 8'h14; w++) send_word(8'(w), 1'b0, 1'b0);
        send_word(8'h15, 1'b0, 1'b1);
        chk("t5_level", fifo_level, 4);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_drops", drop_count, 2);
        for (int k = 8'h12; k <= 8'h15; k++) begin
            chk("t5_pop_order", out_data, k);
            step(1'b0, 2'b00, 1'b1);
        end

        // Drop counter saturation
        for (int w = 0; w < DEPTH + 256; w++) send_word(8'(w * 7), 1'b0, 1'b0);
        chk("sat_drop_count", drop_count, 255);
        idle(DEPTH + 1, 1'b1);

        // Reset with FIFO entries and a partial word in flight
        send_word(8'h42, 1'b0, 1'b0);
        send_word(8'h24, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        apply_reset("t6_reset");
        send_word(8'hFF, 1'b0, 1'b0);
        chk("t6_level", fifo_level, 1);
        chk("t6_data", out_data, 8'hFF);
        idle(1, 1'b1);
        chk("t6_empty", out_valid, 0);

        // Randomized traffic with varying beat density
        thr = 90;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       thr = 95;
                    1:       thr = 70;
                    default: thr = 40;
                endcase
            end
            if (c == 1500) apply_reset("rand_reset");
            step($urandom_range(0, 99) < thr, 2'($urandom), $urandom_range(0, 99) < 60);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
